// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants: ALU op codes, forwarding selects, datapath defaults
package core_pkg;

  localparam int CORE_WIDTH      = 32;
  localparam int CORE_REG_ADDR_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b1001;
  localparam logic [3:0] ALU_AND  = 4'b1010;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/forward_mux.sv
// rtl/forward_mux.sv - forwarding select and data mux for one source operand
module forward_mux
  import core_pkg::*;
#(
  parameter int WIDTH      = CORE_WIDTH,
  parameter int REG_ADDR_W = CORE_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [WIDTH-1:0]      reg_data,
  input  logic                  exm_reg_write,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic [WIDTH-1:0]      exm_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [WIDTH-1:0]      wb_result,
  output logic [1:0]            sel,
  output logic [WIDTH-1:0]      data
);

  // EX/MEM is the younger producer, so it wins over MEM/WB; x0 never forwards
  always_comb begin
    sel  = FWD_REG;
    data = reg_data;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs)) begin
      sel  = FWD_EXM;
      data = exm_result;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
      sel  = FWD_WB;
      data = wb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use detect
module id_ex_stage
  import core_pkg::*;
#(
  parameter int WIDTH      = CORE_WIDTH,
  parameter int REG_ADDR_W = CORE_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [WIDTH-1:0]      id_pc,
  input  logic [WIDTH-1:0]      id_rs1_data,
  input  logic [WIDTH-1:0]      id_rs2_data,
  input  logic [WIDTH-1:0]      id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [3:0]            id_alu_control,
  input  logic                  id_alu_src_pc,
  input  logic                  id_alu_src_imm,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  exm_reg_write,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic [WIDTH-1:0]      exm_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [WIDTH-1:0]      wb_result,
  output logic [WIDTH-1:0]      alu_data1,
  output logic [WIDTH-1:0]      alu_data2,
  output logic [3:0]            alu_control,
  output logic [WIDTH-1:0]      ex_store_data,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [WIDTH-1:0]      ex_pc,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  load_use_hazard
);

  typedef struct packed {
    logic                  valid;
    logic [WIDTH-1:0]      pc;
    logic [WIDTH-1:0]      rs1_data;
    logic [WIDTH-1:0]      rs2_data;
    logic [WIDTH-1:0]      imm;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [3:0]            alu_control;
    logic                  alu_src_pc;
    logic                  alu_src_imm;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } idex_t;

  idex_t idex_d, idex_q;
  logic [WIDTH-1:0] fwd_a, fwd_b;

  always_comb begin
    idex_d = idex_q;
    if (flush) begin
      idex_d = '0;
    end else if (stall) begin
      // A held instruction must not lose a producer that retires from MEM/WB meanwhile
      if (wb_reg_write && (wb_rd != '0) && (wb_rd == idex_q.rs1)) idex_d.rs1_data = wb_result;
      if (wb_reg_write && (wb_rd != '0) && (wb_rd == idex_q.rs2)) idex_d.rs2_data = wb_result;
    end else begin
      idex_d.valid       = id_valid;
      idex_d.pc          = id_pc;
      idex_d.rs1_data    = id_rs1_data;
      idex_d.rs2_data    = id_rs2_data;
      idex_d.imm         = id_imm;
      idex_d.rs1         = id_rs1;
      idex_d.rs2         = id_rs2;
      idex_d.rd          = id_rd;
      idex_d.alu_control = id_valid ? id_alu_control : 4'b0000;
      idex_d.alu_src_pc  = id_valid & id_alu_src_pc;
      idex_d.alu_src_imm = id_valid & id_alu_src_imm;
      idex_d.reg_write   = id_valid & id_reg_write;
      idex_d.mem_read    = id_valid & id_mem_read;
      idex_d.mem_write   = id_valid & id_mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  forward_mux #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs            (idex_q.rs1),
    .reg_data      (idex_q.rs1_data),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .sel           (fwd_sel_a),
    .data          (fwd_a)
  );

  forward_mux #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs            (idex_q.rs2),
    .reg_data      (idex_q.rs2_data),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .sel           (fwd_sel_b),
    .data          (fwd_b)
  );

  assign alu_data1     = idex_q.alu_src_pc  ? idex_q.pc  : fwd_a;
  assign alu_data2     = idex_q.alu_src_imm ? idex_q.imm : fwd_b;
  assign ex_store_data = fwd_b;
  assign alu_control   = idex_q.alu_control;
  assign ex_valid      = idex_q.valid;
  assign ex_reg_write  = idex_q.reg_write;
  assign ex_mem_read   = idex_q.mem_read;
  assign ex_mem_write  = idex_q.mem_write;
  assign ex_rd         = idex_q.rd;
  assign ex_pc         = idex_q.pc;

  assign load_use_hazard = idex_q.valid & idex_q.mem_read & (idex_q.rd != '0) & id_valid &
                           ((idex_q.rd == id_rs1) | (idex_q.rd == id_rs2));

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid, id_alu_src_pc, id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_control;
  logic        stall = 1'b0, flush = 1'b0;
  logic        exm_reg_write, wb_reg_write;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_result, wb_result;
  logic [31:0] alu_data1, alu_data2, ex_store_data, ex_pc;
  logic [3:0]  alu_control;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
  logic [4:0]  ex_rd;
  logic [1:0]  fwd_sel_a, fwd_sel_b;

  int vectors = 0;
  int miscompares = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_control(id_alu_control),
    .id_alu_src_pc(id_alu_src_pc), .id_alu_src_imm(id_alu_src_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_control(alu_control),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_pc(ex_pc),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  // Reference model: what the EX slot holds, in instruction terms
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, r1d, r2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        spc, simm, rw, mr, mw;
  } mdl_t;

  mdl_t m = '0;
  logic [95:0] e_data;
  logic [45:0] e_ctrl;
  logic [4:0]  e_fwd;

  function automatic logic [33:0] fwd(input logic [4:0] rs, input logic [31:0] regval);
    if (exm_reg_write && exm_rd != 0 && exm_rd == rs) return {2'b01, exm_result};
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs)    return {2'b10, wb_result};
    return {2'b00, regval};
  endfunction

  task automatic step();
    mdl_t nx = m;
    if (rst || flush) nx = '0;
    else if (stall) begin
      if (wb_reg_write && wb_rd != 0 && wb_rd == m.rs1) nx.r1d = wb_result;
      if (wb_reg_write && wb_rd != 0 && wb_rd == m.rs2) nx.r2d = wb_result;
    end else begin
      nx.valid = id_valid; nx.pc = id_pc; nx.r1d = id_rs1_data; nx.r2d = id_rs2_data;
      nx.imm = id_imm; nx.rs1 = id_rs1; nx.rs2 = id_rs2; nx.rd = id_rd;
      if (id_valid) begin
        nx.op = id_alu_control; nx.spc = id_alu_src_pc; nx.simm = id_alu_src_imm;
        nx.rw = id_reg_write; nx.mr = id_mem_read; nx.mw = id_mem_write;
      end else begin
        nx.op = 0; nx.spc = 0; nx.simm = 0; nx.rw = 0; nx.mr = 0; nx.mw = 0;
      end
    end
    @(posedge clk);
    m = nx;
    #1;
  endtask

  task automatic expect_outputs();
    logic [33:0] fa, fb;
    logic        lu;
    fa = fwd(m.rs1, m.r1d);
    fb = fwd(m.rs2, m.r2d);
    lu = m.valid && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs1 || m.rd == id_rs2);
    e_data = {(m.spc ? m.pc : fa[31:0]), (m.simm ? m.imm : fb[31:0]), fb[31:0]};
    e_ctrl = {m.op, m.valid, m.rw, m.mr, m.mw, m.rd, m.pc};
    e_fwd  = {fa[33:32], fb[33:32], lu};
  endtask

  task automatic rand_id();
    id_valid = $urandom_range(0, 3) != 0;
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
    id_rd = 5'($urandom_range(0, 7)); id_alu_control = 4'($urandom);
    id_alu_src_pc = 1'($urandom); id_alu_src_imm = 1'($urandom);
    id_reg_write = 1'($urandom); id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
  endtask

  task automatic rand_bypass();
    exm_reg_write = 1'($urandom); exm_rd = 5'($urandom_range(0, 7)); exm_result = $urandom;
    wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_result = $urandom;
  endtask

  task automatic quiet_bypass();
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic plain_id(input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd);
    id_valid = 1; id_pc = 32'h100; id_imm = 32'hFFFF_FFF0;
    id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2; id_rd = rd;
    id_alu_control = 4'b0001; id_alu_src_pc = 0; id_alu_src_imm = 0;
    id_reg_write = 1; id_mem_read = 0; id_mem_write = 0;
  endtask

  task automatic test_reset();
    rst = 1; rand_id(); rand_bypass();
    step(); rand_id(); step();
    vectors++;
    if ({alu_data1, alu_data2, ex_store_data} !== 96'd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h %h %h want 0", alu_data1, alu_data2, ex_store_data);
    end
    vectors++;
    if ({alu_control, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd, ex_pc} !== 46'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: op=%h v=%b rw=%b mr=%b mw=%b rd=%0d pc=%h want all 0",
               alu_control, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd, ex_pc);
    end
    vectors++;
    if ({fwd_sel_a, fwd_sel_b, load_use_hazard} !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_fwd: sa=%b sb=%b lu=%b want 0", fwd_sel_a, fwd_sel_b, load_use_hazard);
    end
    rst = 0;
  endtask

  task automatic test_simple_load();
    quiet_bypass(); stall = 0; flush = 0;
    plain_id(5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
    step();
    vectors++;
    if (alu_data1 !== 32'd5 || alu_data2 !== 32'd7) begin
      miscompares++;
      $display("FAIL simple_data: got %0d %0d want 5 7", alu_data1, alu_data2);
    end
    vectors++;
    if (alu_control !== 4'b0001 || ex_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL simple_ctrl: op=%b v=%b want 0001 1", alu_control, ex_valid);
    end
    vectors++;
    if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin
      miscompares++;
      $display("FAIL simple_sel: sa=%b sb=%b want 00 00", fwd_sel_a, fwd_sel_b);
    end
  endtask

  task automatic test_forward_priority();
    quiet_bypass();
    plain_id(5'd3, 32'h11, 5'd6, 32'h66, 5'd7);
    step();
    stall = 1;
    exm_reg_write = 1; exm_rd = 3; exm_result = 32'hAAAA;
    wb_reg_write = 1; wb_rd = 3; wb_result = 32'h5555;
    #1;
    vectors++;
    if (alu_data1 !== 32'hAAAA || fwd_sel_a !== 2'b01) begin
      miscompares++;
      $display("FAIL fwd_exm: got %h sel %b want 0000aaaa 01", alu_data1, fwd_sel_a);
    end
    exm_reg_write = 0;
    #1;
    vectors++;
    if (alu_data1 !== 32'h5555 || fwd_sel_a !== 2'b10) begin
      miscompares++;
      $display("FAIL fwd_wb: got %h sel %b want 00005555 10", alu_data1, fwd_sel_a);
    end
    quiet_bypass(); stall = 0;
    plain_id(5'd0, 32'h22, 5'd0, 32'h33, 5'd7);
    step();
    exm_reg_write = 1; exm_rd = 0; exm_result = 32'hAAAA;
    wb_reg_write = 1; wb_rd = 0; wb_result = 32'h5555;
    #1;
    vectors++;
    if (alu_data1 !== 32'h22 || fwd_sel_a !== 2'b00 || ex_store_data !== 32'h33) begin
      miscompares++;
      $display("FAIL fwd_x0: got %h sel %b st %h want 00000022 00 00000033",
               alu_data1, fwd_sel_a, ex_store_data);
    end
    quiet_bypass();
  endtask

  task automatic test_load_use();
    quiet_bypass();
    plain_id(5'd1, 32'd1, 5'd2, 32'd2, 5'd4);
    id_mem_read = 1;
    step();
    id_valid = 1; id_rs1 = 6; id_rs2 = 4;
    #1;
    vectors++;
    if (load_use_hazard !== 1'b1) begin
      miscompares++;
      $display("FAIL load_use_hit: got %b want 1", load_use_hazard);
    end
    plain_id(5'd1, 32'd1, 5'd2, 32'd2, 5'd0);
    id_mem_read = 1;
    step();
    id_valid = 1; id_rs1 = 0; id_rs2 = 0;
    #1;
    vectors++;
    if (load_use_hazard !== 1'b0) begin
      miscompares++;
      $display("FAIL load_use_x0: got %b want 0", load_use_hazard);
    end
  endtask

  task automatic test_stall_refresh();
    quiet_bypass();
    plain_id(5'd9, 32'hDEAD, 5'd10, 32'hBEEF, 5'd5);
    step();
    stall = 1; rand_id();
    step();
    wb_reg_write = 1; wb_rd = 9; wb_result = 32'h1234;
    step();
    quiet_bypass(); rand_id();
    step();
    vectors++;
    if (alu_data1 !== 32'h1234 || alu_data2 !== 32'hBEEF) begin
      miscompares++;
      $display("FAIL stall_refresh: got %h %h want 00001234 0000beef", alu_data1, alu_data2);
    end
    vectors++;
    if (ex_pc !== 32'h100 || ex_rd !== 5'd5 || alu_control !== 4'b0001 || ex_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_hold: pc=%h rd=%0d op=%b v=%b want 00000100 5 0001 1",
               ex_pc, ex_rd, alu_control, ex_valid);
    end
    stall = 0;
  endtask

  task automatic test_flush_stall();
    quiet_bypass();
    plain_id(5'd1, 32'd1, 5'd2, 32'd2, 5'd3);
    id_mem_write = 1; id_alu_control = 4'b1010;
    flush = 1; stall = 1;
    step();
    vectors++;
    if ({ex_valid, ex_reg_write, ex_mem_write, alu_control} !== 7'd0) begin
      miscompares++;
      $display("FAIL flush_stall: v=%b rw=%b mw=%b op=%b want 0 0 0 0000",
               ex_valid, ex_reg_write, ex_mem_write, alu_control);
    end
    flush = 0; stall = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 49) == 0;
      flush = $urandom_range(0, 9) == 0;
      stall = $urandom_range(0, 3) == 0;
      rand_id(); rand_bypass();
      step();
      rand_id(); rand_bypass();
      #1;
      expect_outputs();
      vectors++;
      if ({alu_data1, alu_data2, ex_store_data} !== e_data) begin
        miscompares++;
        $display("FAIL rand_data[%0d]: got %h %h %h want %h", i, alu_data1, alu_data2,
                 ex_store_data, e_data);
      end
      vectors++;
      if ({alu_control, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd, ex_pc} !== e_ctrl) begin
        miscompares++;
        $display("FAIL rand_ctrl[%0d]: got %h want %h", i,
                 {alu_control, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd, ex_pc}, e_ctrl);
      end
      vectors++;
      if ({fwd_sel_a, fwd_sel_b, load_use_hazard} !== e_fwd) begin
        miscompares++;
        $display("FAIL rand_fwd[%0d]: got %b want %b", i,
                 {fwd_sel_a, fwd_sel_b, load_use_hazard}, e_fwd);
      end
    end
    rst = 0; flush = 0; stall = 0;
  endtask

  initial begin
    test_reset();
    test_simple_load();
    test_forward_priority();
    test_load_use();
    test_stall_refresh();
    test_flush_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
